seqdet_sched: RTL and testbench
===============================

Name: seqdet_sched

Overview:
- Round-robin scheduler that shares one serial pattern-detector instance among NREQ requesters.
- Each requester submits a DW-bit word with a req/ack handshake.
- The scheduler clears the detector's history, shifts the granted word into it MSB-first as valid-qualified bits, and counts detector match pulses.
- It returns the hit count and the requester id with a one-cycle done strobe. It sits between the requester ports and the detector's i_valid/i_data/o_en interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, word width shifted per frame.
- CW, 4, hit-counter width, saturating.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  NREQ  per-requester request level; held with data until acked.
- i_data  in  NREQ*DW  requester words; requester r uses bits [r*DW +: DW].
- i_hold  in  1  when high, suppresses the next detector bit (inserts a valid bubble).
- o_ack  out  NREQ  one-hot, 1-cycle pulse; word latched.
- o_busy  out  1  high in every state except IDLE.
- o_det_rst_n  out  1  detector synchronous reset, active-low.
- o_det_valid  out  1  detector i_valid.
- o_det_data  out  1  detector i_data.
- i_det_en  in  1  detector o_en.
- o_done  out  1  1-cycle frame-complete pulse.
- o_done_id  out  clog2(NREQ)  requester id of completed frame; held until next o_done.
- o_hits  out  CW  match count of completed frame; held until next o_done.

Behaviour:
- All outputs are registered. Reset values:
  - o_ack=0, o_busy=0, o_det_valid=0, o_det_data=0, o_done=0, o_done_id=0, o_hits=0.
  - o_det_rst_n=0 while i_rst_n is low, and it goes 1 on the first clock after release.
  - State=IDLE, round-robin pointer=NREQ-1 so requester 0 wins first.
- FSM states: IDLE, FLUSH, SHIFT, DRAIN, DONE.
- IDLE, when any i_req is high:
  - Grant the first requester searching upward from pointer+1 (mod NREQ).
  - Latch its word into the shift register and its id.
  - Pulse o_ack for the winner; pointer=winner.
  - Next state FLUSH.
  - If no request, stay in IDLE.
- FLUSH, exactly 1 cycle:
  - o_det_rst_n=0, o_det_valid=0.
  - Clear the hit counter and bit counter.
  - Next state SHIFT.
- SHIFT, each cycle:
  - If i_hold=0: o_det_valid=1, o_det_data=shift register MSB, shift left, bit counter+1.
  - If i_hold=1: o_det_valid=0, o_det_data holds, counters hold.
  - After the DW-th valid bit is issued, next state DRAIN.
  - A frame always has exactly DW valid bits regardless of i_hold pattern.
- Hit counting:
  - Register v_d = o_det_valid delayed one cycle.
  - In any cycle with v_d=1 and i_det_en=1, the hit counter increments, saturating at 2^CW-1.
  - i_det_en is ignored when v_d=0, because the detector holds o_en through bubbles.
- DRAIN, 1 cycle:
  - o_det_valid=0.
  - Captures the en response to the last bit.
  - Next state DONE.
- DONE, 1 cycle:
  - o_done=1; o_hits and o_done_id are loaded.
  - Next state IDLE.
- Latency:
  - With i_hold=0, ack is at cycle t, first valid bit at t+2, last bit at t+DW+1, and o_done at t+DW+3.
  - Next grant is possible at t+DW+4.
- i_req changes while busy do not affect the current frame. A req dropped before ack is simply not granted.
- Asynchronous reset mid-frame:
  - Immediate return to IDLE with reset values.
  - No o_done for the aborted frame.
  - Pointer resets.
- i_hold is ignored outside SHIFT.

Test Plan:
- Reset, req0 with 0xDD and i_hold=0:
  - o_ack[0] pulses, one o_det_rst_n=0 cycle, then 8 valid bits 1,1,0,1,1,1,0,1.
  - o_done 11 cycles after ack with o_hits=2, o_done_id=0.
- Single-frame hit counts:
  - 0x0D gives o_hits=1.
  - 0x00 gives o_hits=0.
  - 0xFF gives o_hits=0.
- All four reqs held high continuously:
  - Grants in order 0,1,2,3,0.
  - Each o_done_id matches its grant.
  - Frames are spaced 12 cycles apart.
- 0xDD with i_hold toggling 1,0 every cycle during SHIFT:
  - Still exactly 8 valid bits.
  - Detector en held high during bubbles is not double-counted; o_hits=2.
- i_rst_n asserted during the 4th valid bit of a frame:
  - All outputs go to reset values asynchronously; no o_done.
  - After release with req2 pending, the next grant goes to req2 and the frame completes normally.
- CW=2 with a stubbed detector asserting en on every valid bit:
  - o_hits saturates at 3.

Source files
------------

// File: rtl/seqdet_sched.sv
// seqdet_sched
// Round-robin scheduler that time-shares one serial pattern detector among
// NREQ requesters. A granted word is loaded, the detector history is cleared
// for one cycle, the word is shifted out MSB-first as valid-qualified bits,
// and the detector's en pulses are counted. The frame result is returned with
// a one-cycle done strobe.
//
// Handshake: a requester raises i_req[r] with its word on i_data[r*DW +: DW]
// and keeps both stable until it sees o_ack[r] (one-cycle, one-hot). The word
// is latched on the edge that raises o_ack, so the requester may change
// either signal from the ack cycle on.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_req  [NREQ]         request levels
//   i_data [NREQ*DW]      requester words
//   i_hold                inserts a valid bubble while shifting
//   o_ack  [NREQ]         one-hot grant pulse
//   o_busy                high whenever the FSM is not idle
//   o_det_rst_n           detector synchronous reset (active-low)
//   o_det_valid/o_det_data  detector bit stream
//   i_det_en              detector match output
//   o_done                frame-complete pulse
//   o_done_id, o_hits     result of the last completed frame (held)
module seqdet_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BCW = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*DW-1:0] i_data,
  input  logic              i_hold,
  output logic [NREQ-1:0]   o_ack,
  output logic              o_busy,
  output logic              o_det_rst_n,
  output logic              o_det_valid,
  output logic              o_det_data,
  input  logic              i_det_en,
  output logic              o_done,
  output logic [IDW-1:0]    o_done_id,
  output logic [CW-1:0]     o_hits
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [DW-1:0]   sreg;
  logic [BCW-1:0]  bit_cnt;
  logic [CW-1:0]   hit_cnt;
  logic            v_d;
  logic            hit_inc;

  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  cand;

  logic [DW-1:0]   words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = i_data[g*DW +: DW];
  end

  // Search upward from ptr+1, wrapping modulo NREQ; first requester found wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ptr;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!grant_vld && i_req[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // The detector keeps o_en stable through bubbles, so en is only meaningful
  // in the cycle right after a valid bit (v_d).
  assign hit_inc = v_d && i_det_en && (hit_cnt != {CW{1'b1}});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_SHIFT;
      S_SHIFT: if (!i_hold && bit_cnt == BCW'(DW-1)) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= IDW'(NREQ-1);
      id_q        <= '0;
      sreg        <= '0;
      bit_cnt     <= '0;
      hit_cnt     <= '0;
      v_d         <= 1'b0;
      o_ack       <= '0;
      o_busy      <= 1'b0;
      o_det_rst_n <= 1'b0;
      o_det_valid <= 1'b0;
      o_det_data  <= 1'b0;
      o_done      <= 1'b0;
      o_done_id   <= '0;
      o_hits      <= '0;
    end else begin
      o_busy      <= (state_nx != S_IDLE);
      o_ack       <= '0;
      o_done      <= 1'b0;
      o_det_rst_n <= 1'b1;
      v_d         <= o_det_valid;
      if (hit_inc) hit_cnt <= hit_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            o_ack <= NREQ'(1) << grant_id;
            ptr   <= grant_id;
            id_q  <= grant_id;
            sreg  <= words[grant_id];
          end
        end
        S_FLUSH: begin
          o_det_rst_n <= 1'b0;
          o_det_valid <= 1'b0;
          hit_cnt     <= '0;
          bit_cnt     <= '0;
        end
        S_SHIFT: begin
          if (!i_hold) begin
            o_det_valid <= 1'b1;
            o_det_data  <= sreg[DW-1];
            sreg        <= sreg << 1;
            bit_cnt     <= bit_cnt + 1'b1;
          end else begin
            o_det_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          o_det_valid <= 1'b0;
        end
        S_DONE: begin
          // The en response to the last bit lands in this same cycle.
          o_done    <= 1'b1;
          o_done_id <= id_q;
          o_hits    <= hit_inc ? hit_cnt + 1'b1 : hit_cnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seqdet_sched.sv
// Testbench for seqdet_sched: a 1101 overlapping detector drives the main
// instance; a second CW=2 instance uses a stub whose en is high after every
// valid bit.
module tb_seqdet_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic               hold = 1'b0;
  logic [NREQ-1:0]    ack;
  logic               busy, det_rst_n, det_valid, det_data, done;
  logic               det_en = 1'b0;
  logic [IDW-1:0]     done_id;
  logic [CW-1:0]      hits;

  seqdet_sched #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .i_hold(hold),
    .o_ack(ack), .o_busy(busy), .o_det_rst_n(det_rst_n),
    .o_det_valid(det_valid), .o_det_data(det_data), .i_det_en(det_en),
    .o_done(done), .o_done_id(done_id), .o_hits(hits)
  );

  // Overlapping "1101" detector, registered en, holds en through bubbles.
  logic [2:0] det_hist = '0;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      det_hist <= '0;
      det_en   <= 1'b0;
    end else if (det_valid) begin
      det_hist <= {det_hist[1:0], det_data};
      det_en   <= ({det_hist, det_data} == 4'b1101);
    end
  end

  // Saturation instance with an always-matching stub.
  logic [NREQ-1:0]    req_b = '0;
  logic [NREQ*DW-1:0] data_b = '0;
  logic [NREQ-1:0]    ack_b;
  logic               busy_b, drst_b, valid_b, ddata_b, done_b;
  logic               en_b = 1'b0;
  logic [IDW-1:0]     id_b;
  logic [1:0]         hits_b;

  seqdet_sched #(.NREQ(NREQ), .DW(DW), .CW(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_data(data_b), .i_hold(1'b0),
    .o_ack(ack_b), .o_busy(busy_b), .o_det_rst_n(drst_b),
    .o_det_valid(valid_b), .o_det_data(ddata_b), .i_det_en(en_b),
    .o_done(done_b), .o_done_id(id_b), .o_hits(hits_b)
  );

  always @(posedge clk) begin
    if (!drst_b)      en_b <= 1'b0;
    else if (valid_b) en_b <= 1'b1;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected hit count: overlapping occurrences of 1101 in the word, MSB first.
  function automatic int exp_hits(input logic [DW-1:0] w);
    int n;
    logic [3:0] win;
    n = 0;
    for (int i = 0; i <= DW - 4; i++) begin
      win = w[DW-1-i -: 4];
      if (win == 4'b1101) n++;
    end
    return (n > (2**CW - 1)) ? (2**CW - 1) : n;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  int                 cyc = 0;
  logic [NREQ-1:0]    s_req = '0;
  logic [NREQ*DW-1:0] s_data = '0;
  logic               s_hold = 1'b0;
  logic               s_rstn = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_req  <= req;
    s_data <= data;
    s_hold <= hold;
    s_rstn <= rst_n;
  end

  logic [W-1:0] exp_q[$];
  bit           m_idle = 1'b1;
  int           m_ptr = NREQ - 1;
  int           m_ack_cyc = 0;
  int           m_bits = 0;
  int           m_last = 0;
  int           m_id = 0;
  logic [DW-1:0]  m_word = '0;
  logic [CW-1:0]  m_out_hits = '0;
  logic [IDW-1:0] m_out_id = '0;

  int ev_ack_cnt = 0, ev_ack_cyc = 0, ev_ack_id = 0;
  int ev_done_cnt = 0, ev_done_cyc = 0, ev_done_id = 0;
  logic [CW-1:0] ev_done_hits = '0;
  logic [DW-1:0] ev_bits = '0;
  int ev_nbits = 0;
  int grant_log[$];
  int ack_cyc_log[$];
  int done_id_log[$];

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] exp_ack;
    logic            exp_valid, exp_done, exp_drst;
    logic [W-1:0]    ent;
    int              win, c;
    if (!rst_n) begin
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_det_rst_n", det_rst_n, 0);
      chk("rst_det_valid", det_valid, 0);
      chk("rst_det_data", det_data, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_hits", hits, 0);
      m_idle = 1'b1; m_ptr = NREQ - 1; m_bits = 0;
      m_out_hits = '0; m_out_id = '0;
      exp_q.delete();
    end else begin
      exp_ack = '0;
      if (m_idle && s_rstn && s_req != '0) begin
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (win < 0 && s_req[c]) win = c;
        end
        exp_ack[win] = 1'b1;
        m_ptr = win; m_id = win; m_idle = 1'b0;
        m_word = s_data[win*DW +: DW];
        m_ack_cyc = cyc; m_bits = 0;
        exp_q.push_back({IDW'(win), CW'(exp_hits(m_word))});
      end
      chk("ack", ack, exp_ack);
      exp_drst  = s_rstn && !(!m_idle && cyc == m_ack_cyc + 1);
      chk("det_rst_n", det_rst_n, exp_drst);
      exp_valid = !m_idle && (cyc >= m_ack_cyc + 2) && (m_bits < DW) && !s_hold;
      chk("det_valid", det_valid, exp_valid);
      if (exp_valid) begin
        chk("det_data", det_data, m_word[DW-1-m_bits]);
        m_bits++;
        if (m_bits == DW) m_last = cyc;
      end
      exp_done = !m_idle && (m_bits == DW) && (cyc == m_last + 2);
      chk("done", done, exp_done);
      if (exp_done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_without_frame: got done, want no frame pending");
        end else begin
          ent = exp_q.pop_front();
          m_out_id   = ent[W-1:CW];
          m_out_hits = ent[CW-1:0];
        end
        m_idle = 1'b1;
      end
      chk("done_id", done_id, m_out_id);
      chk("hits", hits, m_out_hits);
      chk("busy", busy, !m_idle);
      // Observed-event log used by the directed literal checks.
      if (ack != '0) begin
        ev_ack_cnt++; ev_ack_cyc = cyc; ev_nbits = 0;
        for (int r = 0; r < NREQ; r++) if (ack[r]) ev_ack_id = r;
        grant_log.push_back(ev_ack_id);
        ack_cyc_log.push_back(cyc);
      end
      if (det_valid) begin
        ev_bits = {ev_bits[DW-2:0], det_data};
        ev_nbits++;
      end
      if (done) begin
        ev_done_cnt++; ev_done_cyc = cyc; ev_done_hits = hits; ev_done_id = done_id;
        done_id_log.push_back(done_id);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input int prev, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (ev_ack_cnt > prev) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ack_timeout: got no ack, want ack within %0d cycles", lim);
    end
  endtask

  task automatic wait_done(input int prev, input int lim, input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (toggle) hold = ~hold;
      @(negedge clk); #1;
      if (ev_done_cnt > prev) begin ok = 1'b1; break; end
    end
    hold = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done, want done within %0d cycles", lim);
    end
  endtask

  task automatic run_frame(input int id, input logic [DW-1:0] w, input bit toggle);
    int a0, d0;
    @(posedge clk); #1;
    req[id] = 1'b1;
    data[id*DW +: DW] = w;
    a0 = ev_ack_cnt; d0 = ev_done_cnt;
    wait_ack(a0, 40);
    @(posedge clk); #1;
    req[id] = 1'b0;
    if (toggle) hold = 1'b1;
    wait_done(d0, 60, toggle);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_random(input int ncyc);
    logic [NREQ-1:0] ackv;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk); ackv = ack;
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) begin
        if (req[r] && ackv[r]) begin
          req[r] = ($urandom_range(0, 1) == 1);
          data[r*DW +: DW] = DW'($urandom_range(0, 255));
        end else if (!req[r] && $urandom_range(0, 3) == 0) begin
          req[r] = 1'b1;
          data[r*DW +: DW] = DW'($urandom_range(0, 255));
        end else if (req[r] && $urandom_range(0, 63) == 0) begin
          req[r] = 1'b0;
        end
      end
      hold = ($urandom_range(0, 3) == 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a0, d0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("det_rst_n_after_release", det_rst_n, 1);

    // 0xDD from requester 0, no bubbles.
    run_frame(0, 8'hDD, 1'b0);
    chk("dd_ack_id", ev_ack_id, 0);
    chk("dd_latency", ev_done_cyc - ev_ack_cyc, 11);
    chk("dd_hits", ev_done_hits, 2);
    chk("dd_done_id", ev_done_id, 0);
    chk("dd_bits", ev_bits, 8'hDD);
    chk("dd_nbits", ev_nbits, 8);

    run_frame(0, 8'h0D, 1'b0);
    chk("h0d_hits", ev_done_hits, 1);
    run_frame(0, 8'h00, 1'b0);
    chk("h00_hits", ev_done_hits, 0);
    run_frame(0, 8'hFF, 1'b0);
    chk("hff_hits", ev_done_hits, 0);

    // All requesters held: round-robin order from a fresh pointer.
    do_reset();
    a0 = grant_log.size(); d0 = ev_done_cnt;
    @(posedge clk); #1;
    req  = '1;
    data = {8'h0D, 8'hDD, 8'h5A, 8'h1D};
    for (int i = 0; i < 5; i++) wait_ack(ev_ack_cnt, 40);
    req = '0;
    for (int i = 0; i < 20 && ev_done_cnt < d0 + 5; i++) @(negedge clk);
    #1;
    chk("rr_grant_count", grant_log.size() - a0, 5);
    chk("rr_done_count", ev_done_cnt - d0, 5);
    for (int i = 0; i < 5 && a0 + i < grant_log.size(); i++) begin
      chk("rr_order", grant_log[a0+i], exp_order[i]);
      if (i > 0) chk("rr_spacing", ack_cyc_log[a0+i] - ack_cyc_log[a0+i-1], 12);
    end
    for (int i = 0; i < 5 && d0 + i < done_id_log.size(); i++)
      chk("rr_done_id", done_id_log[d0+i], exp_order[i]);

    // Bubbles every other cycle while shifting.
    run_frame(1, 8'hDD, 1'b1);
    chk("hold_nbits", ev_nbits, 8);
    chk("hold_bits", ev_bits, 8'hDD);
    chk("hold_hits", ev_done_hits, 2);
    chk("hold_done_id", ev_done_id, 1);

    // Asynchronous reset during the 4th valid bit.
    @(posedge clk); #1;
    req[3] = 1'b1; data[3*DW +: DW] = 8'hDD;
    wait_ack(ev_ack_cnt, 40);
    d0 = ev_done_cnt;
    @(posedge clk); #1;
    req[3] = 1'b0;
    req[2] = 1'b1; data[2*DW +: DW] = 8'h0D;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ack", ack, 0);
    chk("ar_busy", busy, 0);
    chk("ar_det_rst_n", det_rst_n, 0);
    chk("ar_det_valid", det_valid, 0);
    chk("ar_done", done, 0);
    chk("ar_hits", hits, 0);
    chk("ar_done_id", done_id, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    a0 = ev_ack_cnt;
    chk("ar_no_done", ev_done_cnt, d0);
    wait_ack(a0, 40);
    chk("ar_regrant_id", ev_ack_id, 2);
    @(posedge clk); #1;
    req[2] = 1'b0;
    wait_done(d0, 40, 1'b0);
    chk("ar_hits_after", ev_done_hits, 1);
    chk("ar_id_after", ev_done_id, 2);

    // Randomized traffic against the model.
    run_random(900);
    @(posedge clk); #1;
    req = '0; hold = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("drain_idle", busy, 0);

    // Saturation with CW=2.
    @(posedge clk); #1;
    req_b[0] = 1'b1; data_b[DW-1:0] = 8'hA5;
    @(posedge clk); #1;
    req_b[0] = 1'b0;
    for (int i = 0; i < 40 && !done_b; i++) @(negedge clk);
    chk("sat_done", done_b, 1);
    chk("sat_hits", hits_b, 3);
    chk("sat_id", id_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
